// File: rtl/fpf_enc_arbiter_if.sv
// rtl/fpf_enc_arbiter_if.sv - requester and result stream bundle for the shared FPF encoder arbiter
interface fpf_enc_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 26,
    parameter int CODE_W = 38,
    parameter int TAG_W  = 2
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [CODE_W-1:0]      out_code;
    logic [TAG_W-1:0]       out_tag;

    // Arbiter side: consumes requester words, produces tagged codes.
    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_valid,
        output out_code,
        output out_tag,
        input  out_ready
    );

    // Environment side: word sources and the downstream driver.
    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_valid,
        input  out_code,
        input  out_tag,
        output out_ready
    );
endinterface

// File: rtl/fpf_enc_arbiter.sv
// rtl/fpf_enc_arbiter.sv - round-robin sharing of one FPF_encoder_38 with latency tracking and credit-protected output buffer
module fpf_enc_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_W     = 26,   // binary word width of the 38-bit FPF encoder
    parameter int CODE_W     = 38,
    parameter int TAG_W      = 2,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                clock,
    input  logic                rst_n,
    fpf_enc_arbiter_if.slave    bus,
    output logic [DATA_W-1:0]   enc_datain,
    input  logic [CODE_W-1:0]   enc_codeout,
    output logic                busy,
    output logic [31:0]         word_cnt
);
    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 2;
    localparam int ENT_W = CODE_W + TAG_W;
    localparam logic [TAG_W-1:0] RR_INIT = TAG_W'(NREQ - 1);

    // Encoder pipeline tracking: v1/tag1 mark a word on enc_datain,
    // v2/tag2 mark the code the encoder is presenting on enc_codeout.
    logic             v1;
    logic             v2;
    logic [TAG_W-1:0] tag1;
    logic [TAG_W-1:0] tag2;
    logic [TAG_W-1:0] rr;

    // Output FIFO; each entry is {code, tag}.
    logic [ENT_W-1:0] obuf [OBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] buf_count;
    logic [ENT_W-1:0] head;

    logic             grant_ok;
    logic             grant_any;
    logic [TAG_W-1:0] grant_lane;
    int               best_dist;
    logic             out_valid;
    logic             push;
    logic             pop;

    // Distance of a lane from the slot after the round-robin pointer.
    function automatic int rr_dist(input int lane, input int ptr);
        return (lane + NREQ - 1 - ptr) % NREQ;
    endfunction

    // Words already committed (buffered or still inside the encoder) reserve
    // a buffer slot each, so a granted word can never find the buffer full.
    assign grant_ok = (buf_count + CNT_W'(v1) + CNT_W'(v2)) < CNT_W'(OBUF_DEPTH);

    // Round-robin pick: nearest valid lane after rr, one-hot ready on that lane only.
    always_comb begin
        best_dist     = NREQ;
        grant_lane    = '0;
        grant_any     = 1'b0;
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && (rr_dist(i, int'(rr)) < best_dist)) begin
                best_dist  = rr_dist(i, int'(rr));
                grant_lane = TAG_W'(i);
            end
        end
        if (grant_ok && (best_dist < NREQ)) begin
            grant_any = 1'b1;
            bus.req_ready[grant_lane] = 1'b1;
        end
    end

    // Accept stage: register the granted word toward the encoder; datain holds when idle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            enc_datain <= '0;
            v1         <= 1'b0;
            tag1       <= '0;
            rr         <= RR_INIT;
            word_cnt   <= '0;
        end else if (grant_any) begin
            enc_datain <= bus.req_data[int'(grant_lane)*DATA_W +: DATA_W];
            v1         <= 1'b1;
            tag1       <= grant_lane;
            rr         <= grant_lane;
            word_cnt   <= word_cnt + 32'd1;
        end else begin
            v1         <= 1'b0;
        end
    end

    // Follow the encoder's internal register so the tag lines up with codeout.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            tag2 <= '0;
        end else begin
            v2   <= v1;
            tag2 <= tag1;
        end
    end

    // Codeout is only trusted when v2 is set; this hides the encoder's unreset state.
    assign push = v2;
    assign pop  = out_valid & bus.out_ready;

    // Buffer storage needs no reset: reads are masked while the buffer is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            obuf[wr_ptr] <= {enc_codeout, tag2};
        end
    end

    // Buffer pointers and occupancy; push and pop together leave the count alone.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + CNT_W'(1);
                2'b01:   buf_count <= buf_count - CNT_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    assign head          = obuf[rd_ptr];
    assign out_valid     = (buf_count != '0);
    assign bus.out_valid = out_valid;
    assign bus.out_code  = out_valid ? head[ENT_W-1:TAG_W] : '0;
    assign bus.out_tag   = out_valid ? head[TAG_W-1:0]     : '0;
    assign busy          = v1 | v2 | out_valid;

    // A code arriving from the encoder must always find a free slot.
    a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
        !(push && (buf_count == CNT_W'(OBUF_DEPTH))));

    // Never more than one requester granted at a time.
    a_onehot_grant: assert property (@(posedge clock) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    // A stalled head keeps its code and tag until it is taken.
    a_head_stable: assert property (@(posedge clock) disable iff (!rst_n)
        (out_valid && !bus.out_ready) |=> (out_valid && $stable(bus.out_code) && $stable(bus.out_tag)));
endmodule

// File: tb/tb_fpf_enc_arbiter.sv
// tb/tb_fpf_enc_arbiter.sv - randomized and directed self-checking bench for fpf_enc_arbiter
module tb_fpf_enc_arbiter;
    localparam int NREQ       = 4;
    localparam int DATA_W     = 26;
    localparam int CODE_W     = 38;
    localparam int TAG_W      = 2;
    localparam int OBUF_DEPTH = 4;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] enc_datain;
    logic [CODE_W-1:0] enc_codeout;
    logic              busy;
    logic [31:0]       word_cnt;

    fpf_enc_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .CODE_W(CODE_W), .TAG_W(TAG_W)) bus ();

    fpf_enc_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .CODE_W(CODE_W), .TAG_W(TAG_W), .OBUF_DEPTH(OBUF_DEPTH)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .bus         (bus),
        .enc_datain  (enc_datain),
        .enc_codeout (enc_codeout),
        .busy        (busy),
        .word_cnt    (word_cnt)
    );

    always #5 clock = ~clock;

    // Golden FPF encoder: greedy Fibonacci (Zeckendorf) weights 1,2,3,5,8,...
    function automatic logic [CODE_W-1:0] fpf_code(input logic [DATA_W-1:0] d);
        longint w [CODE_W];
        longint rem;
        logic [CODE_W-1:0] c;
        w[0] = 1;
        w[1] = 2;
        for (int k = 2; k < CODE_W; k++) w[k] = w[k-1] + w[k-2];
        rem = longint'(d);
        c = '0;
        for (int k = CODE_W - 1; k >= 0; k--) begin
            if (rem >= w[k]) begin
                c[k] = 1'b1;
                rem -= w[k];
            end
        end
        return c;
    endfunction

    // Encoder stand-in: unreset register, re-registered every clock.
    initial enc_codeout = '1;
    always @(posedge clock) enc_codeout <= fpf_code(enc_datain);

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [CODE_W-1:0] code;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t            exp_q [$];
    exp_t            m_e;
    int              outstanding = 0;
    int              last_lane   = NREQ - 1;
    int              acc_cnt     = 0;
    int              m_lane;
    int              m_take;
    logic [NREQ-1:0] m_want;
    logic [NREQ-1:0] m_hs;

    // Reference model: credit = words accepted but not yet taken downstream;
    // grant goes to the first valid lane after the last granted one.
    always @(negedge clock) begin
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            last_lane   = NREQ - 1;
            acc_cnt     = 0;
        end else begin
            check("busy", busy, outstanding != 0);
            check("word_cnt", word_cnt, acc_cnt);
            if (outstanding == 0) check("out_valid_idle", bus.out_valid, 0);
            m_want = '0;
            m_lane = -1;
            if (outstanding < OBUF_DEPTH) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_lane < 0 && bus.req_valid[(last_lane + k) % NREQ]) m_lane = (last_lane + k) % NREQ;
                end
            end
            if (m_lane >= 0) m_want[m_lane] = 1'b1;
            check("req_ready", bus.req_ready, m_want);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_out", bus.out_valid, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("out_code", bus.out_code, m_e.code);
                    check("out_tag", bus.out_tag, m_e.tag);
                end
                if (outstanding > 0) outstanding--;
            end
            m_hs   = bus.req_valid & bus.req_ready;
            m_take = -1;
            for (int k = 0; k < NREQ; k++) if (m_hs[k] && m_take < 0) m_take = k;
            if (m_take >= 0) begin
                exp_q.push_back('{code: fpf_code(bus.req_data[m_take*DATA_W +: DATA_W]), tag: TAG_W'(m_take)});
                outstanding++;
                acc_cnt++;
                last_lane = m_take;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        while (busy && n < 64) begin
            tick();
            n++;
        end
        @(negedge clock);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        @(negedge clock);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_enc_datain", enc_datain, 0);
        check("rst_out_code", bus.out_code, 0);
        check("rst_out_tag", bus.out_tag, 0);

        // Single words on lane 2 with exact two-cycle latency
        tick();
        bus.out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            bus.req_valid = 4'b0100;
            bus.req_data[2*DATA_W +: DATA_W] = DATA_W'(j);
            @(negedge clock);
            check("single_ready", bus.req_ready, 4'b0100);
            tick();
            bus.req_valid = '0;
            @(negedge clock);
            check("single_lat0", bus.out_valid, 0);
            @(negedge clock);
            check("single_lat1", bus.out_valid, 0);
            @(negedge clock);
            check("single_valid", bus.out_valid, 1);
            check("single_code", bus.out_code, j);
            check("single_tag", bus.out_tag, 2);
            tick();
        end
        wait_idle("single");

        // All lanes valid: one grant per clock, rotating 0,1,2,3
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        rand_data();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("rotate", bus.req_ready, NREQ'(1) << (i % NREQ));
            tick();
            rand_data();
        end
        bus.req_valid = '0;
        @(negedge clock);
        check("rotate_cnt", word_cnt, 100);
        wait_idle("rotate");

        // Backpressure: exactly OBUF_DEPTH accepts, then one-cycle credit lag on drain
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_valid = '1;
        rand_data();
        repeat (10) begin
            tick();
            rand_data();
        end
        @(negedge clock);
        check("bp_stall", bus.req_ready, 0);
        check("bp_cnt", word_cnt, OBUF_DEPTH);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp_lag", bus.req_ready, 0);
        check("bp_head", bus.out_valid, 1);
        tick();
        @(negedge clock);
        check("bp_resume", bus.req_ready, 4'b0001);
        repeat (6) tick();
        wait_idle("bp");

        // Push and pop together with three entries buffered
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0010;
        rand_data();
        repeat (3) begin
            tick();
            rand_data();
        end
        bus.req_valid = '0;
        repeat (3) tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0010;
        rand_data();
        @(negedge clock);
        check("pp_credit", bus.req_ready, 4'b0010);
        check("pp_cnt", word_cnt, 4);
        tick();
        @(negedge clock);
        check("pp_full", bus.req_ready, 0);
        wait_idle("pp");

        // Reset with v1, v2 set and two words buffered
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0001;
        rand_data();
        tick();
        rand_data();
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        bus.req_valid = 4'b0001;
        rand_data();
        tick();
        rand_data();
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_word_cnt", word_cnt, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        rand_data();
        @(negedge clock);
        check("mid_rst_first", bus.req_ready, 4'b0001);
        check("mid_rst_no_stale", bus.out_valid, 0);
        repeat (8) begin
            tick();
            rand_data();
        end
        wait_idle("mid_rst");

        // Random traffic on valid, data and out_ready
        do_reset();
        cyc = 0;
        while (acc_cnt < 10000 && cyc < 40000) begin
            bus.req_valid = NREQ'($urandom);
            rand_data();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
            cyc++;
        end
        check("rand_words", acc_cnt >= 10000, 1);
        wait_idle("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
